// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - scans a captured "KEY=[-]DIGITS" payload one byte per clock into a signed command.
// Optional hex ("0x" prefix) support is enabled by defining CMD_HEX_EN.
module uart_cmd_parser #(
    parameter int VAL_W      = 32,
    parameter int MAX_DIGITS = 10
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [1023:0]    rx_string,
    input  logic [7:0]       rx_length,
    input  logic             rx_done,
    output logic             busy,
    output logic             cmd_vld,
    output logic [7:0]       cmd_key,
    output logic [VAL_W-1:0] cmd_value,
    output logic             cmd_err,
    output logic [2:0]       err_code,
    output logic             cmd_drop
);
    localparam int ACC_W = VAL_W + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 2);
    localparam logic [ACC_W-1:0] POS_MAX = {{5{1'b0}}, {(VAL_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_MAX = POS_MAX + 1'b1;

    localparam logic [2:0] E_LEN   = 3'd1;
    localparam logic [2:0] E_KEY   = 3'd2;
    localparam logic [2:0] E_EQ    = 3'd3;
    localparam logic [2:0] E_DIGIT = 3'd4;
    localparam logic [2:0] E_OVF   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_EQ, S_SIGN, S_DIGIT, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [1023:0]      buf_q;
    logic [7:0]         len_q;
    logic [7:0]         idx_q, idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               hex_q, hex_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         key_q, key_d;
    logic [2:0]         code_q, code_d;

    logic [7:0]         cur_byte;
    logic               is_last;
    logic               is_digit;
    logic [3:0]         nib;
    logic               x_prefix;
    logic               load;
    logic [ACC_W-1:0]   acc_dec, acc_hex, acc_step, acc_lim;

    assign cur_byte = buf_q[{idx_q[6:0], 3'b000} +: 8];
    assign is_last  = (idx_q == len_q - 8'd1);
    // The strobe cycle still counts as busy, so a new frame is only taken the cycle after it.
    assign busy     = (state_q != S_IDLE) || cmd_vld || cmd_err;
    assign load     = (state_q == S_IDLE) && rx_done && !cmd_vld && !cmd_err;

    always_comb begin
        is_digit = 1'b0;
        nib      = 4'd0;
        if (cur_byte >= 8'h30 && cur_byte <= 8'h39) begin
            is_digit = 1'b1;
            nib      = cur_byte[3:0];
        end
`ifdef CMD_HEX_EN
        else if (hex_q && ((cur_byte >= 8'h61 && cur_byte <= 8'h66) ||
                           (cur_byte >= 8'h41 && cur_byte <= 8'h46))) begin
            is_digit = 1'b1;
            nib      = cur_byte[3:0] + 4'd9;
        end
`endif
    end

`ifdef CMD_HEX_EN
    // A single leading '0' followed by 'x'/'X' switches to hex and restarts the digit count.
    assign x_prefix = !hex_q && (cnt_q == CNT_W'(1)) && (acc_q == '0) &&
                      (cur_byte == 8'h78 || cur_byte == 8'h58);
`else
    assign x_prefix = 1'b0;
`endif

    assign acc_dec  = (acc_q << 3) + (acc_q << 1) + ACC_W'(nib);
    assign acc_hex  = (acc_q << 4) + ACC_W'(nib);
    assign acc_step = hex_q ? acc_hex : acc_dec;
    assign acc_lim  = neg_q ? NEG_MAX : POS_MAX;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        hex_d   = hex_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_KEY;
                    idx_d   = 8'd0;
                    acc_d   = '0;
                    neg_d   = 1'b0;
                    hex_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_KEY: begin
                if (len_q < 8'd3) begin
                    state_d = S_ERR;
                    code_d  = E_LEN;
                end else if (cur_byte >= 8'h41 && cur_byte <= 8'h5A) begin
                    key_d   = cur_byte;
                    idx_d   = idx_q + 8'd1;
                    state_d = S_EQ;
                end else begin
                    state_d = S_ERR;
                    code_d  = E_KEY;
                end
            end
            S_EQ: begin
                if (cur_byte == 8'h3D) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_SIGN;
                end else begin
                    state_d = S_ERR;
                    code_d  = E_EQ;
                end
            end
            S_SIGN, S_DIGIT: begin
                if (state_q == S_SIGN && cur_byte == 8'h2D) begin
                    if (is_last) begin
                        state_d = S_ERR;
                        code_d  = E_DIGIT;
                    end else begin
                        neg_d   = 1'b1;
                        idx_d   = idx_q + 8'd1;
                        state_d = S_DIGIT;
                    end
                end else if (x_prefix) begin
                    if (is_last) begin
                        state_d = S_ERR;
                        code_d  = E_DIGIT;
                    end else begin
                        hex_d   = 1'b1;
                        cnt_d   = '0;
                        idx_d   = idx_q + 8'd1;
                        state_d = S_DIGIT;
                    end
                end else if (!is_digit) begin
                    state_d = S_ERR;
                    code_d  = E_DIGIT;
                end else if (acc_step > acc_lim || cnt_q == CNT_W'(MAX_DIGITS)) begin
                    state_d = S_ERR;
                    code_d  = E_OVF;
                end else begin
                    acc_d   = acc_step;
                    cnt_d   = cnt_q + 1'b1;
                    idx_d   = idx_q + 8'd1;
                    state_d = is_last ? S_DONE : S_DIGIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            hex_q     <= 1'b0;
            cnt_q     <= '0;
            key_q     <= '0;
            code_q    <= '0;
            cmd_vld   <= 1'b0;
            cmd_key   <= '0;
            cmd_value <= '0;
            cmd_err   <= 1'b0;
            err_code  <= '0;
            cmd_drop  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            hex_q    <= hex_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            code_q   <= code_d;
            if (load) begin
                buf_q <= rx_string;
                len_q <= rx_length;
            end
            cmd_vld  <= (state_q == S_DONE);
            cmd_err  <= (state_q == S_ERR);
            cmd_drop <= rx_done && busy;
            if (state_q == S_DONE) begin
                cmd_key   <= key_q;
                cmd_value <= neg_q ? (~acc_q[VAL_W-1:0] + VAL_W'(1)) : acc_q[VAL_W-1:0];
            end
            if (state_q == S_ERR) begin
                err_code <= code_q;
            end
        end
    end
endmodule
